// File: rtl/tf_sched_ctrl.sv
// Twiddle-factor schedule controller: walks (stage, depth) items, issuing one
// generator read per item, waiting out the multiplier latency, then handing
// the result to the consumer with a valid/ready handshake.
module tf_sched_ctrl #(
  parameter int D_WIDTH  = 32,
  parameter int IT_DEPTH = 3,
  parameter int MUL_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         num_stages,
  input  logic               tf_ready,
  output logic               TF_ren,
  output logic               TF_wen,
  output logic [D_WIDTH-1:0] it_depth_cnt,
  output logic [D_WIDTH-1:0] l,
  output logic               tf_valid,
  output logic               busy,
  output logic               done
);

  localparam int DW = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_LAST = DW'(IT_DEPTH - 1);
  localparam logic [2:0]    LAT_LOAD   = 3'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    VALID,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      lat_cnt;
  logic [DW-1:0]   depth_q;
  logic [3:0]      stage_q;
  logic [3:0]      ns_q;
  logic            handshake;
  logic            last_item;
  logic            depth_wrap;
  logic            accept;

  assign handshake  = (state == VALID) && tf_ready;
  assign depth_wrap = (depth_q == DEPTH_LAST);
  assign last_item  = depth_wrap && (stage_q == ns_q - 4'd1);
  assign accept     = (state == IDLE) && start && (num_stages != 4'd0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection; abort overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_stages != 4'd0) ? ISSUE : DONE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (lat_cnt == 3'd0) state_nxt = VALID;
      end
      VALID: begin
        if (tf_ready) state_nxt = last_item ? DONE : ISSUE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  // Latency, depth and stage counters plus the latched stage count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= '0;
      depth_q <= '0;
      stage_q <= '0;
      ns_q    <= '0;
    end else if (abort && (state != IDLE)) begin
      lat_cnt <= '0;
      depth_q <= '0;
      stage_q <= '0;
    end else begin
      if (accept) begin
        ns_q    <= num_stages;
        depth_q <= '0;
        stage_q <= '0;
      end
      if (state == ISSUE) lat_cnt <= LAT_LOAD;
      else if ((state == WAIT) && (lat_cnt != 3'd0)) lat_cnt <= lat_cnt - 3'd1;
      if (handshake) begin
        // the final item returns both counters to zero so DONE reports 0/0
        if (last_item) begin
          depth_q <= '0;
          stage_q <= '0;
        end else if (depth_wrap) begin
          depth_q <= '0;
          stage_q <= stage_q + 4'd1;
        end else begin
          depth_q <= depth_q + DW'(1);
        end
      end
    end
  end

  // Outputs decoded from state; counters are already registered
  always_comb begin
    TF_ren       = (state == ISSUE);
    tf_valid     = (state == VALID);
    TF_wen       = tf_valid && tf_ready;
    busy         = (state == ISSUE) || (state == WAIT) || (state == VALID);
    done         = (state == DONE);
    it_depth_cnt = D_WIDTH'(depth_q);
    l            = D_WIDTH'(stage_q);
  end

endmodule

// File: tb/tb_tf_sched_ctrl.sv
// Directed bench for tf_sched_ctrl with default parameters.
module tb_tf_sched_ctrl;

  localparam int NC = 80;
  localparam int SEL_REN = 0, SEL_WEN = 1, SEL_VALID = 2, SEL_DONE = 3,
                 SEL_BOTH = 4, SEL_VDEPTH = 5;

  logic        clk = 1'b0;
  logic        rst, start, abort, tf_ready;
  logic [3:0]  num_stages;
  logic        TF_ren, TF_wen, tf_valid, busy, done;
  logic [31:0] it_depth_cnt, l;

  int tests = 0;
  int fails = 0;

  logic        log_ren[NC], log_wen[NC], log_valid[NC], log_done[NC], log_busy[NC];
  logic [31:0] log_depth[NC], log_l[NC];

  tf_sched_ctrl #(.D_WIDTH(32), .IT_DEPTH(3), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_stages(num_stages), .tf_ready(tf_ready),
    .TF_ren(TF_ren), .TF_wen(TF_wen), .it_depth_cnt(it_depth_cnt), .l(l),
    .tf_valid(tf_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic sel_bit(input int sel, input int c);
    case (sel)
      SEL_REN:    return log_ren[c];
      SEL_WEN:    return log_wen[c];
      SEL_VALID:  return log_valid[c];
      SEL_DONE:   return log_done[c];
      SEL_BOTH:   return log_ren[c] && log_wen[c];
      SEL_VDEPTH: return log_valid[c] && (log_depth[c] != 32'd0);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int count(input int sel, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (sel_bit(sel, c)) n++;
    return n;
  endfunction

  function automatic int nth(input int sel, input int n, input int ncyc);
    int k = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (sel_bit(sel, c)) begin
        if (k == n) return c;
        k++;
      end
    end
    return -1;
  endfunction

  // Cycle c is the cycle during which the inputs below are applied; start in
  // cycle 0 makes cycle 1 the first ISSUE. Called at posedge+1.
  task automatic run(input logic [3:0] ns, input logic [3:0] ns_after, input int ncyc,
                     input int rlo, input int rhi, input int abort_cyc,
                     input int sa, input int sb, input int sc);
    for (int c = 0; c < ncyc; c++) begin
      start      = (c == 0) || (c == sa) || (c == sb) || (c == sc);
      num_stages = (c == 0) ? ns : ns_after;
      tf_ready   = !((c >= rlo) && (c <= rhi));
      abort      = (c == abort_cyc);
      #1;
      log_ren[c]   = TF_ren;
      log_wen[c]   = TF_wen;
      log_valid[c] = tf_valid;
      log_done[c]  = done;
      log_busy[c]  = busy;
      log_depth[c] = it_depth_cnt;
      log_l[c]     = l;
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    abort    = 1'b0;
    tf_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tf_ready = 1'b1; num_stages = 4'd0;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(tf_valid), 0);
    check("rst_ren_wen", 32'({TF_ren, TF_wen}), 0);
    check("rst_done", 32'(done), 0);
    check("rst_depth", it_depth_cnt, 0);
    check("rst_l", l, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single stage, consumer always ready
    run(4'd1, 4'd1, 16, 100, 0, -1, -1, -1, -1);
    check("t1_ren_cnt", 32'(count(SEL_REN, 0, 15)), 3);
    check("t1_ren0", 32'(nth(SEL_REN, 0, 16)), 1);
    check("t1_ren1", 32'(nth(SEL_REN, 1, 16)), 5);
    check("t1_ren2", 32'(nth(SEL_REN, 2, 16)), 9);
    check("t1_depth@1", log_depth[1], 0);
    check("t1_depth@5", log_depth[5], 1);
    check("t1_depth@9", log_depth[9], 2);
    check("t1_wen0", 32'(nth(SEL_WEN, 0, 16)), 4);
    check("t1_wen1", 32'(nth(SEL_WEN, 1, 16)), 8);
    check("t1_wen2", 32'(nth(SEL_WEN, 2, 16)), 12);
    check("t1_done", 32'(nth(SEL_DONE, 0, 16)), 13);
    check("t1_done_cnt", 32'(count(SEL_DONE, 0, 15)), 1);
    check("t1_l@9", log_l[9], 0);
    check("t1_l@13", log_l[13], 0);
    check("t1_busy@1", 32'(log_busy[1]), 1);
    check("t1_busy@13", 32'(log_busy[13]), 0);
    check("t1_both", 32'(count(SEL_BOTH, 0, 15)), 0);

    // two stages, consumer stalls the first VALID for 5 cycles
    run(4'd2, 4'd2, 36, 4, 8, -1, -1, -1, -1);
    check("t2_valid_hold", 32'(count(SEL_VALID, 0, 9)), 6);
    check("t2_depth_stable", 32'(count(SEL_VDEPTH, 4, 9)), 0);
    check("t2_wen_in_stall", 32'(count(SEL_WEN, 0, 9)), 1);
    check("t2_wen0", 32'(nth(SEL_WEN, 0, 36)), 9);
    check("t2_wen_total", 32'(count(SEL_WEN, 0, 35)), 6);
    check("t2_ren3", 32'(nth(SEL_REN, 3, 36)), 18);
    check("t2_l_item2", log_l[14], 0);
    check("t2_l_item3", log_l[18], 1);
    check("t2_done", 32'(nth(SEL_DONE, 0, 36)), 30);
    check("t2_both", 32'(count(SEL_BOTH, 0, 35)), 0);

    // zero stages goes straight to DONE
    run(4'd0, 4'd0, 4, 100, 0, -1, -1, -1, -1);
    check("t3_done", 32'(nth(SEL_DONE, 0, 4)), 1);
    check("t3_ren", 32'(count(SEL_REN, 0, 3)), 0);
    check("t3_wen", 32'(count(SEL_WEN, 0, 3)), 0);
    check("t3_busy", 32'(log_busy[1]), 0);

    // abort in second WAIT cycle of (stage 1, depth 2)
    run(4'd2, 4'd2, 40, 100, 0, 23, -1, -1, -1);
    check("t4_issue@21", 32'(log_ren[21]), 1);
    check("t4_l@23", log_l[23], 1);
    check("t4_depth@23", log_depth[23], 2);
    check("t4_busy@24", 32'(log_busy[24]), 0);
    check("t4_valid@24", 32'(log_valid[24]), 0);
    check("t4_l@24", log_l[24], 0);
    check("t4_depth@24", log_depth[24], 0);
    check("t4_no_done", 32'(count(SEL_DONE, 0, 39)), 0);
    check("t4_idle_after", 32'(count(SEL_REN, 24, 39)), 0);
    run(4'd1, 4'd1, 16, 100, 0, -1, -1, -1, -1);
    check("t4_rerun_done", 32'(nth(SEL_DONE, 0, 16)), 13);
    check("t4_rerun_wen", 32'(count(SEL_WEN, 0, 15)), 3);

    // start while busy and start with done ignored; start in next IDLE taken
    run(4'd1, 4'd2, 40, 100, 0, -1, 3, 13, 14);
    check("t6_ren_first", 32'(count(SEL_REN, 0, 13)), 3);
    check("t6_done0", 32'(nth(SEL_DONE, 0, 40)), 13);
    check("t6_busy@14", 32'(log_busy[14]), 0);
    check("t6_ren@15", 32'(log_ren[15]), 1);
    check("t6_done1", 32'(nth(SEL_DONE, 1, 40)), 39);
    check("t6_done_cnt", 32'(count(SEL_DONE, 0, 39)), 2);

    // asynchronous reset during VALID of depth 1
    num_stages = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("t5_valid_pre", 32'(tf_valid), 1);
    check("t5_depth_pre", it_depth_cnt, 1);
    rst = 1'b1;
    #1;
    check("t5_valid_async", 32'(tf_valid), 0);
    check("t5_busy_async", 32'(busy), 0);
    check("t5_depth_async", it_depth_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("t5_stay_idle", 32'({busy, TF_ren, done}), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tf_sched_ctrl.md
TF_SCHED_CTRL -- requirements
Module: tf_sched_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- D_WIDTH, 32, width of it_depth_cnt and l.
- IT_DEPTH, 3, depth iterations per stage.
- MUL_LAT, 2, modular-multiplier latency in cycles; legal range 1..7.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- start, in, 1, single-cycle request to begin a schedule.
- abort, in, 1, synchronous cancel.
- num_stages, in, 4, number of stages to run; sampled at start.
- tf_ready, in, 1, consumer accepts the current twiddle factor.
- TF_ren, out, 1, twiddle read strobe to the generator.
- TF_wen, out, 1, write-back strobe to the generator.
- it_depth_cnt, out, D_WIDTH, current depth index.
- l, out, D_WIDTH, current stage index.
- tf_valid, out, 1, generator result valid to the consumer.
- busy, out, 1, schedule in progress.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, VALID and DONE.
REQ-004 In IDLE, start=1 with num_stages>0 SHALL latch num_stages, clear the stage and depth counters, and go to ISSUE next cycle.
REQ-005 In IDLE, start=1 with num_stages=0 SHALL go directly to DONE, with no TF_ren or TF_wen asserted.
REQ-006 In ISSUE, TF_ren SHALL be 1 for exactly one cycle, lat_cnt SHALL be loaded with MUL_LAT-1, and the FSM SHALL go to WAIT.
REQ-007 In WAIT, TF_ren SHALL be 0 and lat_cnt SHALL decrement each cycle; when lat_cnt reaches 0 the FSM SHALL go to VALID.
REQ-008 In VALID, tf_valid SHALL be 1.
REQ-009 TF_wen SHALL equal tf_valid AND tf_ready.
REQ-010 The FSM SHALL hold in VALID while tf_ready=0, with tf_valid, it_depth_cnt and l stable.
REQ-011 On a VALID handshake (tf_ready=1), the depth counter SHALL increment. When it reaches IT_DEPTH-1 it SHALL wrap to 0 and the stage counter SHALL increment.
REQ-012 After the handshake, the FSM SHALL go to DONE if that was the last depth of the last stage; otherwise it SHALL go to ISSUE.
REQ-013 it_depth_cnt SHALL equal the depth counter zero-extended to D_WIDTH; l SHALL equal the stage counter zero-extended to D_WIDTH. Both are registered outputs.
REQ-014 With tf_ready held at 1, each (stage, depth) item SHALL take MUL_LAT+2 cycles (ISSUE, then MUL_LAT cycles to VALID, then the handshake). A full schedule SHALL take num_stages*IT_DEPTH*(MUL_LAT+2) cycles plus one cycle for DONE.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE.
REQ-016 busy SHALL be 1 in ISSUE, WAIT and VALID, and 0 in IDLE and DONE.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-019 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle, clear all counters and deassert TF_ren, TF_wen and tf_valid, with no done pulse.
REQ-020 abort SHALL take priority over start and over a same-cycle handshake.
REQ-021 In no cycle SHALL TF_ren and TF_wen both be 1.
REQ-022 A change of num_stages after start SHALL have no effect on the schedule in progress.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, all counters 0, and TF_ren, TF_wen, tf_valid, busy, done = 0, it_depth_cnt = 0 and l = 0, regardless of clk.
REQ-024 Reset asserted mid-schedule SHALL discard all progress; after rst deasserts, the block SHALL remain in IDLE until a new start.

Verification
REQ-025 Defaults, tf_ready=1, start with num_stages=1 -> TF_ren pulses at cycles 1, 5 and 9 after start. it_depth_cnt=0,1,2 on those pulses. TF_wen pulses at cycles 4, 8 and 12. done pulses at cycle 13. l=0 throughout.
REQ-026 num_stages=2, tf_ready=0 for the first 5 cycles of the first VALID -> tf_valid held for 6 cycles with it_depth_cnt=0 stable. TF_wen pulses once, on the cycle tf_ready rises. 6 items complete in total; l steps 0->1 after the third handshake.
REQ-027 start with num_stages=0 -> done pulses the next cycle; TF_ren and TF_wen are never asserted.
REQ-028 abort in the second WAIT cycle of item (stage 1, depth 2) -> next cycle: IDLE, busy=0, l=0, it_depth_cnt=0, no done. A subsequent start runs a complete schedule.
REQ-029 rst asserted asynchronously during VALID -> tf_valid and busy drop to 0 before the next clk edge. A second start pulse while busy, and a start coincident with done, are both ignored.
